// File: rtl/crit_arb_pkg.sv
// rtl/crit_arb_pkg.sv - shared state encoding and round-robin pick helper for crit_path_arbiter
package crit_arb_pkg;

  localparam int unsigned PICK_MAX = 8;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of mask scanning ptr, ptr+1, ... modulo n (n need not be a power of two).
  function automatic pick_t rr_pick(input logic [PICK_MAX-1:0] mask,
                                    input logic [2:0]          ptr,
                                    input int unsigned         n);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < PICK_MAX; k++) begin
      j = (32'(ptr) + k) % n;
      if (k < n && !r.found && mask[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotate-priority encoder starting at ptr
module rr_priority_pick #(
  parameter int N_REQ = 4,
  localparam int PW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] mask,
  input  logic [PW-1:0]    ptr,
  output logic             found,
  output logic [PW-1:0]    idx
);
  import crit_arb_pkg::*;

  pick_t pick;

  always_comb begin
    pick  = rr_pick(PICK_MAX'(mask), 3'(ptr), N_REQ);
    found = pick.found;
    idx   = PW'(pick.idx);
  end

endmodule

// File: rtl/crit_path_arbiter.sv
// rtl/crit_path_arbiter.sv - round-robin arbiter with qualified critical priority, hold limits and a one-cycle turnaround
module crit_path_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MIN_HOLD  = 2,
  parameter int MAX_GRANT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        crit,
  input  logic                    cond1,
  input  logic                    cond2,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  output logic                    owner_crit
);
  import crit_arb_pkg::*;

  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_GRANT + 1);
  localparam logic [HW-1:0] MIN_HOLD_C  = HW'(MIN_HOLD);
  localparam logic [HW-1:0] MAX_GRANT_C = HW'(MAX_GRANT);
  localparam logic [PW-1:0] LAST_IDX    = PW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                owner_crit_q, owner_crit_d;

  logic                crit_en;
  logic [N_REQ-1:0]    crit_mask;
  logic                c_found, a_found;
  logic [PW-1:0]       c_idx, a_idx, win_idx;
  logic                win_crit, rel, preempt, fair;

  assign crit_en   = cond1 & cond2;
  assign crit_mask = req & crit;

  rr_priority_pick #(.N_REQ(N_REQ)) u_pick_crit (
    .mask (crit_mask), .ptr (rr_ptr_q), .found (c_found), .idx (c_idx)
  );

  rr_priority_pick #(.N_REQ(N_REQ)) u_pick_all (
    .mask (req), .ptr (rr_ptr_q), .found (a_found), .idx (a_idx)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    hold_cnt_d   = hold_cnt_q;
    grant_d      = grant_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    owner_crit_d = owner_crit_q;

    win_crit = crit_en && c_found;
    win_idx  = win_crit ? c_idx : a_idx;
    rel      = !req[owner_q];
    preempt  = crit_en && !owner_crit_q && (hold_cnt_q >= MIN_HOLD_C) && |(crit_mask & ~grant_q);
    fair     = (hold_cnt_q >= MAX_GRANT_C) && |(req & ~grant_q);

    case (state_q)
      GRANT: begin
        out_data_d = data_in[owner_q*DATA_W +: DATA_W];
        hold_cnt_d = (hold_cnt_q == MAX_GRANT_C) ? MAX_GRANT_C : hold_cnt_q + 1'b1;
        if (rel || preempt || fair) begin
          state_d      = TURN;
          grant_d      = '0;
          out_valid_d  = 1'b0;
          owner_crit_d = 1'b0;
          hold_cnt_d   = '0;
        end
      end
      default: begin
        // IDLE and TURN share the arbitration step; TURN's own outputs are already cleared.
        grant_d     = '0;
        out_valid_d = 1'b0;
        state_d     = IDLE;
        if (a_found) begin
          state_d      = GRANT;
          owner_d      = win_idx;
          grant_d      = ONE << win_idx;
          rr_ptr_d     = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          hold_cnt_d   = HW'(1);
          out_valid_d  = 1'b1;
          out_data_d   = data_in[win_idx*DATA_W +: DATA_W];
          owner_crit_d = win_crit;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      hold_cnt_q   <= '0;
      grant_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      owner_crit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      hold_cnt_q   <= hold_cnt_d;
      grant_q      <= grant_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      owner_crit_q <= owner_crit_d;
    end
  end

  assign grant      = grant_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign owner_crit = owner_crit_q;

endmodule

// File: tb/tb_crit_path_arbiter.sv
// tb/tb_crit_path_arbiter.sv - directed self-checking bench for crit_path_arbiter
module tb_crit_path_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  crit;
  logic        cond1;
  logic        cond2;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        owner_crit;

  int passed = 0;
  int total  = 0;

  crit_path_arbiter #(.N_REQ(4), .DATA_W(8), .MIN_HOLD(2), .MAX_GRANT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .crit       (crit),
    .cond1      (cond1),
    .cond2      (cond2),
    .data_in    (data_in),
    .grant      (grant),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .owner_crit (owner_crit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] oh;

    rst_n   = 1'b0;
    req     = '0;
    crit    = '0;
    cond1   = 1'b0;
    cond2   = 1'b0;
    data_in = {8'h43, 8'h32, 8'h21, 8'h10};

    // Reset and idle
    repeat (3) step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    step();
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_valid", 32'(out_valid), 32'h0);

    // Round robin 0,1,2,3 with a one-cycle bubble between owners
    req = 4'b1111;
    for (int o = 0; o < 4; o++) begin
      step();
      oh = 4'b0001 << o;
      chk("rr_grant", 32'(grant), 32'(oh));
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_data", 32'(out_data), 32'((o + 1) * 16 + o));
      step();
      chk("rr_hold1", 32'(grant), 32'(oh));
      step();
      chk("rr_hold2", 32'(grant), 32'(oh));
      req[o] = 1'b0;
      step();
      chk("rr_turn_grant", 32'(grant), 32'h0);
      chk("rr_turn_valid", 32'(out_valid), 32'h0);
      chk("rr_turn_data", 32'(out_data), 32'((o + 1) * 16 + o));
      req[o] = 1'b1;
    end
    step();
    chk("rr_wrap_grant", 32'(grant), 32'h1);
    chk("rr_wrap_data", 32'(out_data), 32'h10);

    // Asynchronous reset in the middle of a grant
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_data", 32'(out_data), 32'h0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Critical gated off by cond2=0: plain round robin from 0
    req   = 4'b0101;
    crit  = 4'b0100;
    cond1 = 1'b1;
    cond2 = 1'b0;
    step();
    chk("gate_off_grant", 32'(grant), 32'h1);
    chk("gate_off_crit", 32'(owner_crit), 32'h0);
    req = '0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Critical qualified: requester 2 wins over 0 from rr_ptr 0
    req   = 4'b0101;
    cond2 = 1'b1;
    step();
    chk("gate_on_grant", 32'(grant), 32'h4);
    chk("gate_on_crit", 32'(owner_crit), 32'h1);
    chk("gate_on_data", 32'(out_data), 32'h32);
    req  = '0;
    crit = '0;
    step();
    chk("gate_on_turn_crit", 32'(owner_crit), 32'h0);
    step();

    // Preemption only once hold_cnt reaches MIN_HOLD (rr_ptr is 3 here)
    req = 4'b0010;
    step();
    chk("pre_grant1", 32'(grant), 32'h2);
    chk("pre_crit1", 32'(owner_crit), 32'h0);
    req  = 4'b1010;
    crit = 4'b1000;
    step();
    chk("pre_no_preempt", 32'(grant), 32'h2);
    step();
    chk("pre_turn", 32'(grant), 32'h0);
    chk("pre_turn_valid", 32'(out_valid), 32'h0);
    step();
    chk("pre_new_grant", 32'(grant), 32'h8);
    chk("pre_new_crit", 32'(owner_crit), 32'h1);
    chk("pre_new_data", 32'(out_data), 32'h43);
    req  = '0;
    crit = '0;
    step();
    step();

    // Fairness: owner 0 revoked after exactly MAX_GRANT cycles (rr_ptr is 0)
    cond1 = 1'b0;
    cond2 = 1'b0;
    req   = 4'b0001;
    step();
    chk("fair_c1", 32'(grant), 32'h1);
    req = 4'b0101;
    for (int c = 2; c <= 8; c++) begin
      step();
      chk("fair_held", 32'(grant), 32'h1);
    end
    step();
    chk("fair_turn", 32'(grant), 32'h0);
    step();
    chk("fair_next", 32'(grant), 32'h4);
    chk("fair_next_data", 32'(out_data), 32'h32);
    req = '0;
    step();
    step();

    // Sole requester keeps the grant; out_data follows data_in[1] every cycle
    req = 4'b0010;
    step();
    chk("sole_grant0", 32'(grant), 32'h2);
    for (int c = 0; c < 20; c++) begin
      v = 8'($urandom_range(0, 255));
      data_in[15:8] = v;
      step();
      chk("sole_grant", 32'(grant), 32'h2);
      chk("sole_data", 32'(out_data), 32'(v));
    end
    req = '0;
    step();
    chk("sole_release", 32'(grant), 32'h0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
